// File: rtl/gpu_pkg.sv
// Shared types and widths for the per-core block-dispatch logic.
package gpu_pkg;

   localparam int BLOCK_ID_W  = 8;
   localparam int THREAD_ID_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } blk_state_t;

endpackage

// File: rtl/thread_ret_tracker.sv
// Per-lane retirement mask with an all-active-lanes-retired compare.
module thread_ret_tracker #(
   parameter int LANES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [LANES-1:0] thread_ret,
   input  logic [LANES-1:0] thread_enable,
   output logic             all_ret
);

   logic [LANES-1:0] ret_mask_q;
   logic [LANES-1:0] ret_mask_d;
   logic [LANES-1:0] ret_now;

   // Accumulate RETs on enabled lanes only; clear has priority.
   always_comb begin
      ret_now    = thread_ret & thread_enable;
      ret_mask_d = ret_mask_q;
      if (clr) begin
         ret_mask_d = '0;
      end else if (en) begin
         ret_mask_d = ret_mask_q | ret_now;
      end
   end

   // Includes this cycle's RETs so the final retirement completes on its own edge.
   assign all_ret = ((ret_mask_q | ret_now) == thread_enable);

   // Mask register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ret_mask_q <= '0;
      end else begin
         ret_mask_q <= ret_mask_d;
      end
   end

endmodule

// File: rtl/core_block_ctrl.sv
// Per-core responder: accepts a block assignment, launches the pipeline,
// tracks lane retirement and holds core_done until a soft reset.
//
// state  | meaning
// IDLE   | waiting for core_start; latches block id / lane mask on accept
// LAUNCH | one-cycle launch pulse to the pipeline; RETs already counted
// RUN    | waiting for every enabled lane to retire
// DONE   | core_done held until core_reset
module core_block_ctrl
   import gpu_pkg::*;
#(
   parameter int THREADS_PER_BLOCK = 4,
   parameter int TC_W              = $clog2(THREADS_PER_BLOCK) + 1
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     core_reset,
   input  logic                                     core_start,
   input  logic [BLOCK_ID_W-1:0]                    core_block_id,
   input  logic [TC_W-1:0]                          core_thread_count,
   input  logic [THREADS_PER_BLOCK-1:0]             thread_ret,
   output logic                                     core_done,
   output logic                                     launch,
   output logic [THREADS_PER_BLOCK-1:0]             thread_enable,
   output logic [BLOCK_ID_W-1:0]                    block_id,
   output logic [THREAD_ID_W*THREADS_PER_BLOCK-1:0] thread_id,
   output logic                                     cfg_err
);

   blk_state_t                   state_q, state_d;
   logic [THREADS_PER_BLOCK-1:0] thread_enable_q, thread_enable_d;
   logic [BLOCK_ID_W-1:0]        block_id_q, block_id_d;
   logic                         cfg_err_q, cfg_err_d;

   logic [THREADS_PER_BLOCK-1:0] start_mask;
   logic                         count_over;
   logic                         trk_clr;
   logic                         trk_en;
   logic                         all_ret;

   // Lane mask for an incoming assignment; counts above the lane total saturate.
   always_comb begin
      start_mask = '0;
      for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
         start_mask[i] = (i < int'(core_thread_count));
      end
      count_over = (int'(core_thread_count) > THREADS_PER_BLOCK);
   end

   // Next-state logic; core_reset overrides everything but leaves block_id and cfg_err.
   always_comb begin
      state_d         = state_q;
      thread_enable_d = thread_enable_q;
      block_id_d      = block_id_q;
      cfg_err_d       = cfg_err_q;
      trk_clr         = 1'b0;
      trk_en          = 1'b0;
      if (core_reset) begin
         state_d         = IDLE;
         thread_enable_d = '0;
         trk_clr         = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (core_start) begin
                  block_id_d      = core_block_id;
                  thread_enable_d = start_mask;
                  trk_clr         = 1'b1;
                  if (count_over) begin
                     cfg_err_d = 1'b1;
                  end
                  state_d = (core_thread_count == '0) ? DONE : LAUNCH;
               end
            end
            LAUNCH: begin
               trk_en  = 1'b1;
               state_d = RUN;
            end
            RUN: begin
               trk_en = 1'b1;
               if (all_ret) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and assignment registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         thread_enable_q <= '0;
         block_id_q      <= '0;
         cfg_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         thread_enable_q <= thread_enable_d;
         block_id_q      <= block_id_d;
         cfg_err_q       <= cfg_err_d;
      end
   end

   thread_ret_tracker #(
      .LANES(THREADS_PER_BLOCK)
   ) u_tracker (
      .clk          (clk),
      .reset        (reset),
      .clr          (trk_clr),
      .en           (trk_en),
      .thread_ret   (thread_ret),
      .thread_enable(thread_enable_q),
      .all_ret      (all_ret)
   );

   // Global IDs wrap at 256; product formed at 16 bits before truncation.
   for (genvar g = 0; g < THREADS_PER_BLOCK; g++) begin : g_tid
      assign thread_id[g*THREAD_ID_W +: THREAD_ID_W] =
         THREAD_ID_W'(16'(block_id_q) * 16'(THREADS_PER_BLOCK) + 16'(g));
   end

   assign launch        = (state_q == LAUNCH);
   assign core_done     = (state_q == DONE);
   assign thread_enable = thread_enable_q;
   assign block_id      = block_id_q;
   assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_core_block_ctrl.sv
// Bench for core_block_ctrl: assignment-level model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_core_block_ctrl;

   localparam int T    = 4;
   localparam int TC_W = 3;

   logic            clk;
   logic            reset;
   logic            core_reset;
   logic            core_start;
   logic [7:0]      core_block_id;
   logic [TC_W-1:0] core_thread_count;
   logic [T-1:0]    thread_ret;
   logic            core_done;
   logic            launch;
   logic [T-1:0]    thread_enable;
   logic [7:0]      block_id;
   logic [8*T-1:0]  thread_id;
   logic            cfg_err;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_on = 0;

   core_block_ctrl #(.THREADS_PER_BLOCK(T), .TC_W(TC_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .core_reset       (core_reset),
      .core_start       (core_start),
      .core_block_id    (core_block_id),
      .core_thread_count(core_thread_count),
      .thread_ret       (thread_ret),
      .core_done        (core_done),
      .launch           (launch),
      .thread_enable    (thread_enable),
      .block_id         (block_id),
      .thread_id        (thread_id),
      .cfg_err          (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Assignment-level model: age = edges since the start was accepted (-1 = no assignment).
   int         m_age  = -1;
   bit         m_done = 0;
   logic [3:0] m_en   = '0;
   logic [3:0] m_ret  = '0;
   logic [7:0] m_bid  = '0;
   bit         m_cfg  = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_age = -1; m_done = 0; m_en = '0; m_ret = '0; m_bid = '0; m_cfg = 0;
      end else if (core_reset) begin
         m_age = -1; m_done = 0; m_en = '0; m_ret = '0;
      end else if (m_age < 0) begin
         if (core_start) begin
            int n;
            n     = (int'(core_thread_count) < T) ? int'(core_thread_count) : T;
            m_bid = core_block_id;
            if (int'(core_thread_count) > T) m_cfg = 1;
            m_en  = 4'((1 << n) - 1);
            m_ret = '0;
            if (n == 0) begin
               m_done = 1;
               m_age  = 1000;
            end else begin
               m_age = 1;
            end
         end
      end else if (!m_done) begin
         bit in_run;
         in_run = (m_age >= 2);
         m_ret  = m_ret | (thread_ret & m_en);
         if (in_run && m_ret == m_en) m_done = 1;
         m_age++;
      end
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      if (chk_on) begin
         logic [8*T-1:0] exp_tid;
         for (int i = 0; i < T; i++) exp_tid[i*8 +: 8] = 8'((int'(m_bid) * T + i) % 256);
         chk("core_done",     32'(core_done),     32'(m_done));
         chk("launch",        32'(launch),        32'(m_age == 1 && !m_done));
         chk("thread_enable", 32'(thread_enable), 32'(m_en));
         chk("block_id",      32'(block_id),      32'(m_bid));
         chk("thread_id",     32'(thread_id),     32'(exp_tid));
         chk("cfg_err",       32'(cfg_err),       32'(m_cfg));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [7:0] id, input logic [TC_W-1:0] cnt);
      core_start        = 1'b1;
      core_block_id     = id;
      core_thread_count = cnt;
   endtask

   task automatic soft_reset();
      core_start = 1'b0;
      thread_ret = '0;
      core_reset = 1'b1;
      tick(1);
      core_reset = 1'b0;
   endtask

   initial begin
      reset             = 1'b0;
      core_reset        = 1'b0;
      core_start        = 1'b0;
      core_block_id     = '0;
      core_thread_count = '0;
      thread_ret        = '0;
      #12;
      chk("rst_thread_id", 32'(thread_id), 32'h03020100);
      chk("rst_outputs", {26'd0, core_done, launch, cfg_err, 3'd0} | 32'(thread_enable) | 32'(block_id), 32'd0);
      reset = 1'b1;
      tick(1);
      chk_on = 1;

      // Full block: id 3, four lanes, RETs in separate RUN cycles.
      start(8'd3, 3'd4);
      tick(1);
      chk("n_launch", 32'(launch), 32'd1);
      chk("n_enable", 32'(thread_enable), 32'hF);
      chk("n_tid", 32'(thread_id), 32'h0F0E0D0C);
      tick(1);
      for (int i = 0; i < T; i++) begin
         chk("n_not_done", 32'(core_done), 32'd0);
         thread_ret = 4'(1 << i);
         tick(1);
      end
      thread_ret = '0;
      chk("n_done", 32'(core_done), 32'd1);
      core_start = 1'b0;
      tick(3);
      chk("n_done_held", 32'(core_done), 32'd1);
      soft_reset();
      chk("n_sr_done", 32'(core_done), 32'd0);
      chk("n_sr_bid", 32'(block_id), 32'd3);

      // Partial block: id 2, three lanes; lane 3 RETs ignored.
      start(8'd2, 3'd3);
      tick(1);
      chk("p_enable", 32'(thread_enable), 32'h7);
      core_start = 1'b0;
      thread_ret = 4'b1001;
      tick(1);
      thread_ret = 4'b0010;
      tick(1);
      thread_ret = 4'b1000;
      tick(1);
      chk("p_not_done", 32'(core_done), 32'd0);
      thread_ret = 4'b0100;
      tick(1);
      thread_ret = '0;
      chk("p_done", 32'(core_done), 32'd1);
      soft_reset();

      // Zero threads: straight to done, no launch.
      start(8'd5, 3'd0);
      tick(1);
      chk("z_launch", 32'(launch), 32'd0);
      chk("z_done", 32'(core_done), 32'd1);
      soft_reset();

      // Oversized count with wrap-around IDs: id 70, count 6; RETs during LAUNCH.
      start(8'd70, 3'd6);
      tick(1);
      chk("o_enable", 32'(thread_enable), 32'hF);
      chk("o_cfg", 32'(cfg_err), 32'd1);
      chk("o_tid", 32'(thread_id), 32'h1B1A1918);
      core_start = 1'b0;
      thread_ret = 4'b1111;
      tick(1);
      thread_ret = '0;
      chk("o_run_not_done", 32'(core_done), 32'd0);
      tick(1);
      chk("o_done", 32'(core_done), 32'd1);
      soft_reset();
      chk("o_cfg_sticky", 32'(cfg_err), 32'd1);

      // Abort mid-RUN with two lanes retired; pending RETs discarded.
      start(8'd1, 3'd4);
      tick(1);
      core_start = 1'b0;
      tick(1);
      thread_ret = 4'b0011;
      tick(1);
      thread_ret = 4'b1100;
      core_reset = 1'b1;
      tick(1);
      core_reset = 1'b0;
      thread_ret = '0;
      chk("a_done", 32'(core_done), 32'd0);
      start(8'd1, 3'd4);
      tick(1);
      core_start = 1'b0;
      thread_ret = '0;
      tick(1);
      thread_ret = 4'b1100;
      tick(1);
      chk("a_need_fresh", 32'(core_done), 32'd0);
      thread_ret = 4'b0011;
      tick(1);
      thread_ret = '0;
      chk("a_done2", 32'(core_done), 32'd1);
      soft_reset();

      // Reset and start together: reset wins, start taken on the next edge.
      start(8'd9, 3'd2);
      core_reset = 1'b1;
      tick(1);
      chk("pr_no_launch", 32'(launch), 32'd0);
      core_reset = 1'b0;
      tick(1);
      chk("pr_launch", 32'(launch), 32'd1);
      core_start = 1'b0;
      tick(1);

      // Hard reset between edges while in RUN.
      #2;
      reset = 1'b0;
      #1;
      chk("ar_thread_id", 32'(thread_id), 32'h03020100);
      chk("ar_enable", 32'(thread_enable), 32'd0);
      chk("ar_bid", 32'(block_id), 32'd0);
      chk("ar_flags", {29'd0, core_done, launch, cfg_err}, 32'd0);
      tick(1);
      reset = 1'b1;
      tick(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/core_block_ctrl.md
# core_block_ctrl

Per-core responder for the block-dispatch handshake. Each compute core has one instance. It accepts a block assignment from the top-level dispatcher (start, block id, thread count), derives the per-thread enable mask and global thread IDs, and launches the core pipeline. It then tracks per-thread completion and raises `core_done` once every active thread has retired. The block holds that state until the dispatcher soft-resets the core.

## Interface
Parameters:
- `THREADS_PER_BLOCK`, default 4: thread lanes per core. Must be ≥1.
- `TC_W`, default `$clog2(THREADS_PER_BLOCK)+1`: width of the thread-count field.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  hard reset, **asynchronous, active-low**.
- `core_reset`  in  1  dispatcher soft reset, synchronous, active-high.
- `core_start`  in  1  dispatcher start; level, held high for the whole assignment.
- `core_block_id`  in  8  block index, valid when `core_start` is high.
- `core_thread_count`  in  TC_W  number of active threads, valid when `core_start` is high.
- `thread_ret`  in  THREADS_PER_BLOCK  per-lane RET pulse from the pipeline.
- `core_done`  out  1  block finished; level.
- `launch`  out  1  one-cycle pulse telling the pipeline to begin fetch at PC 0.
- `thread_enable`  out  THREADS_PER_BLOCK  active-lane mask.
- `block_id`  out  8  latched block index.
- `thread_id`  out  8 × THREADS_PER_BLOCK  global ID per lane.
- `cfg_err`  out  1  sticky flag: thread count exceeded `THREADS_PER_BLOCK`.

## Operation
- **States:** IDLE, LAUNCH, RUN, DONE.
- **IDLE**
  - If `core_start`=1 and `core_reset`=0: latch `core_block_id`, then compute `tc = min(core_thread_count, THREADS_PER_BLOCK)`.
  - If `core_thread_count` > `THREADS_PER_BLOCK`: set `cfg_err`.
  - Set `thread_enable` = low `tc` bits set and clear `ret_mask`.
  - Next state is LAUNCH. If `tc`=0, go directly to DONE; no `launch` is issued.
- **LAUNCH:** `launch`=1 for exactly this cycle. Next state is RUN unconditionally.
- **RUN:** no extra action; `ret_mask` accumulates as described below.
- **RET accumulation (LAUNCH and RUN):** `ret_mask |= thread_ret & thread_enable`. RET on disabled lanes is ignored.
- **RUN → DONE:** taken when `(ret_mask | (thread_ret & thread_enable)) == thread_enable`.
- **DONE:** `core_done`=1. Stays in DONE regardless of `core_start` or `thread_ret`.
- **Soft reset:** `core_reset`=1 in any state, at the clock edge:
  - Go to IDLE.
  - Clear `core_done`, `ret_mask`, `thread_enable` and `launch`.
  - `block_id` and `thread_id` keep their values.
  - `cfg_err` is *not* cleared.
- **Thread IDs:** `thread_id[i] = (block_id * THREADS_PER_BLOCK + i) mod 256`. Compute at ≥16 bits, then truncate to 8. Combinational from the latched `block_id`.
- **Duplicate RET:** a repeated RET on a lane already marked in `ret_mask` has no effect.

## Timing
- **Hard reset** (`reset`=0) forces, asynchronously, with no clock required:
  - state = IDLE
  - `core_done`=0, `launch`=0, `thread_enable`=0, `block_id`=0, `cfg_err`=0, `ret_mask`=0
  - therefore `thread_id[i]`=i
- **Start-to-launch latency:** start is sampled at edge E0. State is LAUNCH and `launch`=1 in the cycle after E0. `thread_enable` and `block_id` are valid in that same cycle.
- **Done latency:** the final RET is sampled at edge Ek while in RUN. `core_done`=1 from Ek onward. Minimum start-to-done is 2 edges (E0 → LAUNCH → RUN, with all RETs presented during RUN).
- RETs presented during LAUNCH count toward completion; the earliest DONE is still the edge leaving RUN.
- **Simultaneous `core_reset` and `core_start`:** reset wins and the block stays in IDLE. Start is accepted on the first later edge where `core_reset`=0.
- **Mid-operation `core_reset`** (LAUNCH or RUN): the assignment is aborted. Pending RETs in that cycle are discarded.
- **`core_start` deasserted in LAUNCH or RUN:** ignored. Only `core_reset` ends an assignment.
- **Hard reset mid-operation:** immediate return to the reset values listed above.

## Structure
- Shared package `gpu_pkg`:
  - state enum `blk_state_t` (IDLE, LAUNCH, RUN, DONE)
  - `BLOCK_ID_W` = 8
  - `THREAD_ID_W` = 8
- Sub-module `thread_ret_tracker`, parameterized by lane count:
  - holds `ret_mask`, with clear/enable inputs
  - provides an all-retired compare against `thread_enable`
- FSM, latches and ID generation stay in `core_block_ctrl`.

## Test plan
- **Normal block:** T=4, start with block_id=3, count=4. Expect `launch` pulse 1 cycle later, `thread_enable`=4'b1111, `thread_id`={15,14,13,12}. RETs on lanes 0..3 in separate RUN cycles → `core_done`=1 the edge after the lane-3 RET, held until `core_reset`.
- **Partial last block:** block_id=2, count=3. Expect `thread_enable`=4'b0111. RET on lane 3 is ignored. `core_done` asserts only after lanes 0–2 have retired.
- **Boundary counts:**
  - count=0 → no `launch`, `core_done`=1 one edge after start.
  - count=6 → `thread_enable`=4'b1111 and `cfg_err`=1; `cfg_err` survives a later `core_reset`.
- **Wrap-around:** block_id=70, T=4 → `thread_id`={27,26,25,24}, i.e. 280..283 mod 256.
- **Abort and priority:**
  - `core_reset` during RUN with 2 of 4 lanes retired → IDLE, `core_done` stays 0. A new start then requires all 4 fresh RETs.
  - `core_reset` and `core_start` high together → no `launch` that cycle.
- **Async reset:** drive `reset`=0 between clock edges during RUN → all outputs take their reset values immediately, with no clock edge.
